renkon_ctrl_pool: RTL and testbench

Control pipeline for the 2×2, stride-2 max-pooling stage of the renkon convolution core. It sits directly downstream of the bias controller and consumes its begin/valid/end pixel stream, one pixel per valid cycle in raster order. It tracks row and column position and drives the pooling datapath: pair-max reset, line-buffer write/read and pooled-output enable. It also regenerates begin/valid/end for the pooled stream.

---
 rtl/renkon_ctrl_pool.sv | 164 ++++++++++++++++
 tb/tb_renkon_ctrl_pool.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/renkon_ctrl_pool.sv
// renkon_ctrl_pool: control pipeline for the 2x2 stride-2 max-pool stage.
// Tracks raster row/col of the incoming pixel stream and drives the pooling
// datapath (pair-max reset, line-buffer write/read, pooled-output enable),
// and regenerates begin/valid/end for the pooled stream.
//
// Ports:
//   clk, xrst             clock, synchronous active-high reset
//   in_begin/valid/end    pixel stream from the bias stage
//   fea_size              feature-map side length N (square)
//   pool_en               (RENKON_CTRL_POOL_BYPASS_EN only) 0 = pass-through
//   pool_first, buf_we,   d0 controls (1 cycle after input pixel)
//   buf_re, buf_addr,
//   pool_oe
//   out_begin/valid/end   d1 pooled stream (2 cycles after input)
//
// Optional feature macro: RENKON_CTRL_POOL_BYPASS_EN
module renkon_ctrl_pool #(
   parameter int LWIDTH = 5,
   parameter int BWIDTH = LWIDTH - 1
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              in_begin,
   input  logic              in_valid,
   input  logic              in_end,
   input  logic [LWIDTH-1:0] fea_size,
`ifdef RENKON_CTRL_POOL_BYPASS_EN
   input  logic              pool_en,
`endif
   output logic              pool_first,
   output logic              buf_we,
   output logic              buf_re,
   output logic [BWIDTH-1:0] buf_addr,
   output logic              pool_oe,
   output logic              out_begin,
   output logic              out_valid,
   output logic              out_end
);

   // frame tracking
   logic              armed_q, armed_d;
   logic [LWIDTH-1:0] col_q, col_d;
   logic [LWIDTH-1:0] row_q, row_d;

   // d0 stage
   logic              pf_q, pf_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic              oe_q, oe_d;
   logic [BWIDTH-1:0] addr_q, addr_d;
   logic              beg0_q, beg0_d;
   logic              end0_q, end0_d;

   // d1 stage
   logic              obeg_q;
   logic              oval_q;
   logic              oend_q;

   // combinational helpers
   logic [LWIDTH-1:0] col_c, row_c;
   logic [LWIDTH-1:0] last_c, lim_c;
   logic              pix_c, region_c, pool_on_c;

`ifdef RENKON_CTRL_POOL_BYPASS_EN
   assign pool_on_c = pool_en;
`else
   assign pool_on_c = 1'b1;
`endif

   always_comb begin
      // Nothing is produced after reset until a frame has begun;
      // a begin in this cycle arms the pixel arriving with it.
      armed_d = armed_q | in_begin;

      // A coincident begin makes this pixel (0,0).
      col_c = in_begin ? '0 : col_q;
      row_c = in_begin ? '0 : row_q;

      last_c = fea_size - 1'b1;
      // Pooled region edge 2*floor(N/2): drops the odd last row/col.
      lim_c  = {fea_size[LWIDTH-1:1], 1'b0};

      pix_c    = in_valid & armed_d;
      region_c = (col_c < lim_c) && (row_c < lim_c);

      col_d = col_c;
      row_d = row_c;
      if (pix_c) begin
         if (col_c == last_c) begin
            col_d = '0;
            row_d = (row_c == last_c) ? '0 : row_c + 1'b1;
         end else begin
            col_d = col_c + 1'b1;
         end
      end

      pf_d = 1'b0;
      we_d = 1'b0;
      re_d = 1'b0;
      oe_d = 1'b0;
      if (pix_c) begin
         if (!pool_on_c) begin
            pf_d = 1'b1;
            oe_d = 1'b1;
         end else if (region_c) begin
            pf_d = ~col_c[0];
            we_d = ~row_c[0] & col_c[0];
            re_d = row_c[0] & col_c[0];
            oe_d = row_c[0] & col_c[0];
         end
      end

      // Address only moves with an asserted control.
      if (pf_d | we_d | re_d | oe_d)
         addr_d = BWIDTH'(col_c >> 1);
      else
         addr_d = addr_q;

      beg0_d = in_begin;
      end0_d = in_end & armed_d;
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         armed_q <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         pf_q    <= 1'b0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         oe_q    <= 1'b0;
         addr_q  <= '0;
         beg0_q  <= 1'b0;
         end0_q  <= 1'b0;
         obeg_q  <= 1'b0;
         oval_q  <= 1'b0;
         oend_q  <= 1'b0;
      end else begin
         armed_q <= armed_d;
         col_q   <= col_d;
         row_q   <= row_d;
         pf_q    <= pf_d;
         we_q    <= we_d;
         re_q    <= re_d;
         oe_q    <= oe_d;
         addr_q  <= addr_d;
         beg0_q  <= beg0_d;
         end0_q  <= end0_d;
         obeg_q  <= beg0_q;
         oval_q  <= oe_q;
         oend_q  <= end0_q;
      end
   end

   assign pool_first = pf_q;
   assign buf_we     = we_q;
   assign buf_re     = re_q;
   assign buf_addr   = addr_q;
   assign pool_oe    = oe_q;
   assign out_begin  = obeg_q;
   assign out_valid  = oval_q;
   assign out_end    = oend_q;

endmodule

// File: tb/tb_renkon_ctrl_pool.sv
// tb_renkon_ctrl_pool: directed + randomized bench for renkon_ctrl_pool,
// checked cycle by cycle against a pixel-index reference model.
module tb_renkon_ctrl_pool;
   localparam int LW = 5;
   localparam int BW = LW - 1;

   logic          clk = 1'b0;
   logic          xrst = 1'b1;
   logic          in_begin = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_end = 1'b0;
   logic [LW-1:0] fea_size = 5'd4;
   logic          pool_en = 1'b1;
   logic          pool_first, buf_we, buf_re, pool_oe;
   logic [BW-1:0] buf_addr;
   logic          out_begin, out_valid, out_end;

   int total = 0;
   int bad = 0;

   // reference model state
   int k = 0;
   bit armed = 0;
   int n_oe = 0;
   bit e_pf, e_we, e_re, e_oe, e_beg, e_end;
   int e_addr = 0;
   bit e_ob, e_ov, e_oend;
`ifdef RENKON_CTRL_POOL_BYPASS_EN
   bit byp = 1;
`else
   bit byp = 0;
`endif

   renkon_ctrl_pool #(.LWIDTH(LW)) dut (
      .clk(clk), .xrst(xrst),
      .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
      .fea_size(fea_size),
`ifdef RENKON_CTRL_POOL_BYPASS_EN
      .pool_en(pool_en),
`endif
      .pool_first(pool_first), .buf_we(buf_we), .buf_re(buf_re),
      .buf_addr(buf_addr), .pool_oe(pool_oe),
      .out_begin(out_begin), .out_valid(out_valid), .out_end(out_end)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model of one clock edge, from row = k/N, col = k%N of the pixel index.
   task automatic model(bit r, bit b, bit v, bit e);
      int n, row, col, half;
      n = int'(fea_size);
      if (r) begin
         k = 0; armed = 0;
         {e_pf, e_we, e_re, e_oe, e_beg, e_end} = '0;
         {e_ob, e_ov, e_oend} = '0;
         e_addr = 0;
         return;
      end
      e_ov = e_oe; e_ob = e_beg; e_oend = e_end;
      if (b) begin k = 0; armed = 1; end
      e_beg = b;
      e_end = e && armed;
      {e_pf, e_we, e_re, e_oe} = '0;
      if (v && armed) begin
         row = k / n; col = k % n; half = n / 2;
         if (byp && !pool_en) begin
            e_pf = 1; e_oe = 1;
         end else if (row < 2 * half && col < 2 * half) begin
            e_pf = (col % 2 == 0);
            e_we = (row % 2 == 0) && (col % 2 == 1);
            e_re = (row % 2 == 1) && (col % 2 == 1);
            e_oe = e_re;
         end
         if (e_pf || e_we || e_re || e_oe) e_addr = col / 2;
         k = (k + 1) % (n * n);
      end
   endtask

   task automatic step(bit r, bit b, bit v, bit e);
      xrst = r; in_begin = b; in_valid = v; in_end = e;
      @(posedge clk);
      model(r, b, v, e);
      #1;
      chk("pool_first", 32'(pool_first), 32'(e_pf));
      chk("buf_we",     32'(buf_we),     32'(e_we));
      chk("buf_re",     32'(buf_re),     32'(e_re));
      chk("pool_oe",    32'(pool_oe),    32'(e_oe));
      chk("buf_addr",   32'(buf_addr),   32'(e_addr));
      chk("out_begin",  32'(out_begin),  32'(e_ob));
      chk("out_valid",  32'(out_valid),  32'(e_ov));
      chk("out_end",    32'(out_end),    32'(e_oend));
      if (pool_oe === 1'b1) n_oe++;
   endtask

   task automatic run_frame(int n, int gmin, int gmax, bit sep_begin);
      int want;
      fea_size = LW'(n);
      n_oe = 0;
      if (sep_begin) step(0, 1, 0, 0);
      for (int p = 0; p < n * n; p++) begin
         step(0, (p == 0) && !sep_begin, 1, p == n * n - 1);
         repeat ($urandom_range(gmax, gmin)) step(0, 0, 0, 0);
      end
      repeat (3) step(0, 0, 0, 0);
      want = (byp && !pool_en) ? n * n : (n / 2) * (n / 2);
      chk("oe_count", 32'(n_oe), 32'(want));
   endtask

   initial begin
      // reset held with in_valid high, then valid without begin
      repeat (3) step(1, 0, 1, 0);
      repeat (3) step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);

      run_frame(4, 0, 0, 0);
      run_frame(5, 0, 0, 0);
      run_frame(4, 1, 1, 0);
      run_frame(3, 0, 0, 1);
      run_frame(2, 0, 0, 0);

      // reset after pixel 6 of an N=4 frame
      fea_size = 4;
      for (int p = 0; p <= 6; p++) step(0, p == 0, 1, 0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      run_frame(4, 0, 0, 0);

      for (int f = 0; f < 6; f++)
         run_frame(int'($urandom_range(31, 2)), 0,
                   int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));

`ifdef RENKON_CTRL_POOL_BYPASS_EN
      pool_en = 0;
      run_frame(4, 0, 0, 0);
      run_frame(5, 0, 1, 0);
      pool_en = 1;
      run_frame(4, 0, 0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
